eq_gain_ctrl: RTL and testbench

EQ_GAIN_CTRL -- requirements
Module: eq_gain_ctrl

---
 rtl/eq_pkg.sv | 32 +++
 rtl/btn_repeat.sv | 63 ++++++
 rtl/eq_gain_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
//------------------------------------------------------------------------------
// Module : eq_pkg
// Brief  : Shared FSM state encoding and default constants for the EQ gain
//          controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package eq_pkg;

    localparam int DEF_N_BAND     = 8;
    localparam int DEF_GAIN_W     = 6;
    localparam int DEF_GAIN_MAX   = 12;
    localparam int DEF_GAIN_MIN   = -12;
    localparam int DEF_REPEAT_DLY = 500000;
    localparam int DEF_REPEAT_PER = 100000;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_BAND_SEL = 3'd2,
        S_SET_GAIN = 3'd3
    } state_t;

    // Larger of two integers, used to size the repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_repeat.sv
//------------------------------------------------------------------------------
// Module : btn_repeat
// Brief  : Rising-edge press detector with hold-to-repeat. The first event is
//          registered one cycle after the edge; while held, further events
//          follow REPEAT_DLY cycles after the first and then every REPEAT_PER
//          cycles. Repeat events are only emitted while rpt_en is high.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_repeat
    import eq_pkg::*;
#(
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic btn,
    input  logic rpt_en,
    output logic evt
);

    localparam int CNT_W = $clog2(max_int(REPEAT_DLY, REPEAT_PER) + 1);
    localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PER - 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt;
    logic             in_per;

    // Edge detect plus hold counter; release or a fresh edge restarts the delay.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_q  <= 1'b0;
            cnt    <= '0;
            in_per <= 1'b0;
            evt    <= 1'b0;
        end else begin
            btn_q <= btn;
            evt   <= 1'b0;
            if (btn && !btn_q) begin
                evt    <= 1'b1;
                cnt    <= '0;
                in_per <= 1'b0;
            end else if (btn) begin
                if ((!in_per && cnt == DLY_END) || (in_per && cnt == PER_END)) begin
                    evt    <= rpt_en;
                    cnt    <= '0;
                    in_per <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt    <= '0;
                in_per <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eq_gain_ctrl.sv
//------------------------------------------------------------------------------
// Module : eq_gain_ctrl
// Brief  : Button-driven multi-band EQ gain controller. Runs codec init, lets
//          the user pick a band and trim its gain, and streams changed band
//          gains to the DSP over a valid/ready channel, lowest band first.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eq_gain_ctrl
    import eq_pkg::*;
#(
    parameter int N_BAND     = DEF_N_BAND,
    parameter int GAIN_W     = DEF_GAIN_W,
    parameter int GAIN_MAX   = DEF_GAIN_MAX,
    parameter int GAIN_MIN   = DEF_GAIN_MIN,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_select,
    input  logic                        i_back,
    input  logic                        i_up,
    input  logic                        i_down,
    output logic                        o_init_start,
    input  logic                        i_init_done,
    output logic                        o_cfg_valid,
    input  logic                        i_cfg_ready,
    output logic [$clog2(N_BAND)-1:0]   o_cfg_band,
    output logic [GAIN_W-1:0]           o_cfg_gain,
    output logic [2:0]                  o_state,
    output logic [$clog2(N_BAND)-1:0]   o_band,
    output logic [GAIN_W-1:0]           o_gain,
    output logic [N_BAND*GAIN_W-1:0]    o_gains
);

    localparam int BAND_W = $clog2(N_BAND);
    localparam logic signed [GAIN_W-1:0] G_MAX     = GAIN_W'(GAIN_MAX);
    localparam logic signed [GAIN_W-1:0] G_MIN     = GAIN_W'(GAIN_MIN);
    localparam logic signed [GAIN_W-1:0] G_ONE     = GAIN_W'(1);
    localparam logic [BAND_W-1:0]        BAND_LAST = BAND_W'(N_BAND - 1);

    state_t                    state;
    logic                      init_start;
    logic [BAND_W-1:0]         band;
    logic signed [GAIN_W-1:0]  gain [N_BAND];

    logic                      sel_q, back_q, sel_evt, back_evt;
    logic                      up_evt, down_evt;
    logic                      rpt_en;

    logic                      gain_up, gain_dn, gain_chg;
    logic signed [GAIN_W-1:0]  cur_gain, gain_nxt;

    logic [N_BAND-1:0]         pending, pend_nxt;
    logic                      init_mark;
    logic [BAND_W-1:0]         low_band;
    logic                      cfg_valid, inflight_dirty;
    logic [BAND_W-1:0]         cfg_band;
    logic [GAIN_W-1:0]         cfg_gain;

    assign rpt_en = (state == S_SET_GAIN);

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .btn   (i_up),
        .rpt_en(rpt_en),
        .evt   (up_evt)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_down (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .btn   (i_down),
        .rpt_en(rpt_en),
        .evt   (down_evt)
    );

    // Select and back only need a registered one-cycle press event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_q    <= 1'b0;
            back_q   <= 1'b0;
            sel_evt  <= 1'b0;
            back_evt <= 1'b0;
        end else begin
            sel_q    <= i_select;
            back_q   <= i_back;
            sel_evt  <= i_select & ~sel_q;
            back_evt <= i_back & ~back_q;
        end
    end

    // Gain step for the selected band; back and select outrank up/down and
    // a simultaneous up+down is dropped. Saturated steps report no change.
    always_comb begin
        cur_gain = gain[band];
        gain_nxt = cur_gain;
        gain_chg = 1'b0;
        gain_up  = (state == S_SET_GAIN) && !back_evt && !sel_evt && up_evt && !down_evt;
        gain_dn  = (state == S_SET_GAIN) && !back_evt && !sel_evt && down_evt && !up_evt;
        if (gain_up && (cur_gain < G_MAX)) begin
            gain_nxt = cur_gain + G_ONE;
            gain_chg = 1'b1;
        end else if (gain_dn && (cur_gain > G_MIN)) begin
            gain_nxt = cur_gain - G_ONE;
            gain_chg = 1'b1;
        end
    end

    // Main control FSM: init handshake, menu navigation and gain storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_INIT;
            init_start <= 1'b1;
            band       <= '0;
            for (int i = 0; i < N_BAND; i++) begin
                gain[i] <= '0;
            end
        end else begin
            if (gain_chg) begin
                gain[band] <= gain_nxt;
            end
            case (state)
                S_INIT: begin
                    if (i_init_done) begin
                        init_start <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!back_evt && sel_evt) begin
                        state <= S_BAND_SEL;
                    end
                end
                S_BAND_SEL: begin
                    if (back_evt) begin
                        state <= S_IDLE;
                    end else if (sel_evt) begin
                        state <= S_SET_GAIN;
                    end else if (up_evt && !down_evt && band != BAND_LAST) begin
                        band <= band + 1'b1;
                    end else if (down_evt && !up_evt && band != '0) begin
                        band <= band - 1'b1;
                    end
                end
                S_SET_GAIN: begin
                    if (back_evt) begin
                        state <= S_BAND_SEL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign init_mark = (state == S_INIT) && i_init_done;

    // Lowest-numbered pending band wins the next transfer slot.
    always_comb begin
        low_band = '0;
        for (int i = N_BAND - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_band = BAND_W'(i);
            end
        end
    end

    // Pending update: a completed transfer clears its bit unless the band was
    // touched while in flight; a fresh change always sets (set beats clear).
    always_comb begin
        pend_nxt = pending;
        if (init_mark) begin
            pend_nxt = '1;
        end
        if (cfg_valid && i_cfg_ready && !inflight_dirty) begin
            pend_nxt[cfg_band] = 1'b0;
        end
        if (gain_chg) begin
            pend_nxt[band] = 1'b1;
        end
    end

    // Coefficient channel: capture a payload, hold it until accepted, then
    // idle one cycle before the next capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending        <= '0;
            cfg_valid      <= 1'b0;
            cfg_band       <= '0;
            cfg_gain       <= '0;
            inflight_dirty <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (cfg_valid) begin
                if (i_cfg_ready) begin
                    cfg_valid      <= 1'b0;
                    inflight_dirty <= 1'b0;
                end else if (gain_chg && band == cfg_band) begin
                    inflight_dirty <= 1'b1;
                end
            end else if (|pending) begin
                cfg_valid      <= 1'b1;
                cfg_band       <= low_band;
                cfg_gain       <= gain[low_band];
                inflight_dirty <= gain_chg && (band == low_band);
            end
        end
    end

    assign o_state      = state;
    assign o_init_start = init_start;
    assign o_band       = band;
    assign o_gain       = gain[band];
    assign o_cfg_valid  = cfg_valid;
    assign o_cfg_band   = cfg_band;
    assign o_cfg_gain   = cfg_gain;

    generate
        for (genvar gi = 0; gi < N_BAND; gi++) begin : g_pack
            assign o_gains[gi*GAIN_W +: GAIN_W] = gain[gi];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_eq_gain_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_eq_gain_ctrl
// Brief  : Directed self-checking bench for eq_gain_ctrl.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eq_gain_ctrl;

    localparam int DLY = 20;
    localparam int PER = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, back, up, down;
    logic        init_start, init_done;
    logic        cfg_valid, cfg_ready;
    logic [2:0]  cfg_band;
    logic [5:0]  cfg_gain;
    logic [2:0]  state;
    logic [2:0]  band;
    logic [5:0]  gain;
    logic [47:0] gains;

    int errors = 0;
    int checks = 0;

    logic [8:0] sent_q[$];

    eq_gain_ctrl #(
        .N_BAND(8), .GAIN_W(6), .GAIN_MAX(12), .GAIN_MIN(-12),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_select    (sel),
        .i_back      (back),
        .i_up        (up),
        .i_down      (down),
        .o_init_start(init_start),
        .i_init_done (init_done),
        .o_cfg_valid (cfg_valid),
        .i_cfg_ready (cfg_ready),
        .o_cfg_band  (cfg_band),
        .o_cfg_gain  (cfg_gain),
        .o_state     (state),
        .o_band      (band),
        .o_gain      (gain),
        .o_gains     (gains)
    );

    always #5 clk = ~clk;

    // Record every completed transfer as {band, gain}.
    always @(negedge clk) begin
        if (cfg_valid && cfg_ready) begin
            sent_q.push_back({cfg_band, cfg_gain});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic b, input logic u, input logic d);
        sel = s; back = b; up = u; down = d;
        tick(2);
        sel = 1'b0; back = 1'b0; up = 1'b0; down = 1'b0;
        tick(2);
    endtask

    task automatic hold(input logic u, input logic d, input int n);
        up = u; down = d;
        tick(n);
        up = 1'b0; down = 1'b0;
        tick(3);
    endtask

    function automatic logic [63:0] g6(input int v);
        logic [5:0] t;
        t = v[5:0];
        return {58'd0, t};
    endfunction

    function automatic logic [63:0] ent(input int b, input int v);
        logic [2:0] tb_b;
        logic [5:0] tv;
        tb_b = b[2:0];
        tv   = v[5:0];
        return {55'd0, tb_b, tv};
    endfunction

    function automatic logic [63:0] q_at(input int i);
        if (i < sent_q.size()) return {55'd0, sent_q[i]};
        return 64'hdead;
    endfunction

    initial begin
        rst = 1'b1; sel = 1'b0; back = 1'b0; up = 1'b0; down = 1'b0;
        init_done = 1'b0; cfg_ready = 1'b1;
        tick(3);
        check("rst_state", 64'(state), 64'd0);
        check("rst_init_start", 64'(init_start), 64'd1);
        check("rst_band", 64'(band), 64'd0);
        check("rst_gains", 64'(gains), 64'd0);
        check("rst_cfg_valid", 64'(cfg_valid), 64'd0);

        // Init handshake: done pulsed at cycle 10 after release.
        rst = 1'b0;
        tick(9);
        check("init_start_held", 64'(init_start), 64'd1);
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        check("init_start_fall", 64'(init_start), 64'd0);
        check("idle_after_init", 64'(state), 64'd1);
        tick(25);
        check("init_send_count", 64'(sent_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("init_send_%0d", i), q_at(i), ent(i, 0));
        end
        check("init_no_more_valid", 64'(cfg_valid), 64'd0);

        // Band selection saturates at both ends.
        press(1, 0, 0, 0);
        check("band_sel_state", 64'(state), 64'd2);
        for (int i = 0; i < 10; i++) press(0, 0, 1, 0);
        check("band_top", 64'(band), 64'd7);
        for (int i = 0; i < 3; i++) press(0, 0, 1, 0);
        check("band_top_sat", 64'(band), 64'd7);
        for (int i = 0; i < 10; i++) press(0, 0, 0, 1);
        check("band_bottom", 64'(band), 64'd0);
        press(0, 0, 0, 1);
        check("band_bottom_sat", 64'(band), 64'd0);

        // Gain on band 3: step to 11, then hold up into saturation.
        for (int i = 0; i < 3; i++) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("set_gain_state", 64'(state), 64'd3);
        for (int i = 0; i < 11; i++) press(0, 0, 1, 0);
        check("gain_11", 64'(gain), g6(11));
        tick(6);
        sent_q.delete();
        hold(1, 0, DLY + 3*PER);
        tick(7);
        check("gain_sat_max", 64'(gain), g6(12));
        check("gains_band3", 64'(gains[3*6 +: 6]), g6(12));
        check("sat_send_count", 64'(sent_q.size()), 64'd1);
        check("sat_send", q_at(0), ent(3, 12));

        // Hold down: edge step, first repeat, then two periodic repeats.
        hold(0, 1, 33);
        check("repeat_down", 64'(gain), g6(8));
        hold(0, 1, 200);
        check("gain_sat_min", 64'(gain), g6(-12));
        tick(10);
        sent_q.delete();
        press(0, 0, 0, 1);
        tick(6);
        check("min_noop_gain", 64'(gain), g6(-12));
        check("min_noop_no_send", 64'(sent_q.size()), 64'd0);

        // Conflicting buttons.
        press(0, 0, 1, 1);
        check("updown_ignored", 64'(gain), g6(-12));
        press(1, 1, 0, 0);
        check("back_over_sel_gain", 64'(state), 64'd2);
        press(1, 1, 0, 0);
        check("back_over_sel_band", 64'(state), 64'd1);

        // Payload held under backpressure, then band 2 re-sent.
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        check("band_2", 64'(band), 64'd2);
        press(1, 0, 0, 0);
        cfg_ready = 1'b0;
        tick(1);
        sent_q.delete();
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        tick(11);
        check("bp_valid", 64'(cfg_valid), 64'd1);
        check("bp_band", 64'(cfg_band), 64'd2);
        check("bp_gain_held", 64'(cfg_gain), g6(1));
        check("bp_live_gain", 64'(gain), g6(2));
        cfg_ready = 1'b1;
        tick(10);
        check("bp_send_count", 64'(sent_q.size()), 64'd2);
        check("bp_send_0", q_at(0), ent(2, 1));
        check("bp_send_1", q_at(1), ent(2, 2));

        // Reset in the middle of a pending transfer.
        cfg_ready = 1'b0;
        press(0, 0, 1, 0);
        tick(2);
        check("pre_rst_valid", 64'(cfg_valid), 64'd1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_state", 64'(state), 64'd0);
        check("mid_rst_init_start", 64'(init_start), 64'd1);
        check("mid_rst_band", 64'(band), 64'd0);
        check("mid_rst_gains", 64'(gains), 64'd0);
        check("mid_rst_gain", 64'(gain), 64'd0);
        check("mid_rst_valid", 64'(cfg_valid), 64'd0);
        check("mid_rst_cfg", 64'({cfg_band, cfg_gain}), 64'd0);
        cfg_ready = 1'b1;
        sent_q.delete();
        rst = 1'b0;
        tick(3);
        check("reinit_start", 64'(init_start), 64'd1);
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        check("reinit_idle", 64'(state), 64'd1);
        tick(25);
        check("reinit_send_count", 64'(sent_q.size()), 64'd8);
        check("reinit_send_2", q_at(2), ent(2, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
